pipelined_rca_adder: RTL

Parametrised, pipelined ripple-carry adder: generalises the single-bit full adder to WIDTH-bit operands split into SEG_W-bit segments, one segment per pipeline stage, with carry passed stage-to-stage. Accepts one operand pair per cycle under a valid/ready handshake and stalls the whole pipe on output backpressure. Sits between the operand driver and any consumer of sums, and replaces direct combinational instantiation of the full adder in wide datapaths.

---
 rtl/rca_defs_pkg.sv | 27 ++
 rtl/full_adder.sv | 13 +
 rtl/rca_segment.sv | 28 ++
 rtl/pipelined_rca_adder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rca_defs_pkg.sv
// Shared defaults and configuration helpers for the pipelined ripple-carry adder.
// Optional feature macro: RCA_OVERFLOW_EN (adds the registered two's-complement overflow output).
`ifndef RCA_STAGES
`define RCA_STAGES(w, s) ((w) / (s))
`endif

package rca_defs;

  localparam int unsigned RCA_DEF_WIDTH = 32;
  localparam int unsigned RCA_DEF_SEG_W = 8;
  localparam int unsigned RCA_MAX_STAGES = 16;

  function automatic int unsigned rca_stages(input int unsigned width, input int unsigned seg_w);
    return `RCA_STAGES(width, seg_w);
  endfunction

  // Zero when the width splits evenly into segments and the stage count is in range.
  function automatic int unsigned rca_cfg_err(input int unsigned width, input int unsigned seg_w);
    if (seg_w == 0) return 1;
    if ((width % seg_w) != 0) return 1;
    if (`RCA_STAGES(width, seg_w) < 1 || `RCA_STAGES(width, seg_w) > RCA_MAX_STAGES) return 1;
    return 0;
  endfunction

  localparam int unsigned RCA_DEF_CFG_ERR = rca_cfg_err(RCA_DEF_WIDTH, RCA_DEF_SEG_W);

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the leaf cell of every segment ripple chain.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/rca_segment.sv
// Combinational SEG_W-bit ripple chain of full adders; no lookahead.
module rca_segment #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_cin,
  output logic [SEG_W-1:0] o_s,
  output logic             o_cout
);

  logic [SEG_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    full_adder u_fa (
      .i_a    (i_a[i]),
      .i_b    (i_b[i]),
      .i_cin  (w_c[i]),
      .o_s    (o_s[i]),
      .o_cout (w_c[i+1])
    );
  end

  assign o_cout = w_c[SEG_W];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: one SEG_W segment per stage, whole-pipe stall on backpressure.
// Define RCA_OVERFLOW_EN to add the registered two's-complement overflow output.
module pipelined_rca_adder
  import rca_defs::*;
#(
  parameter int unsigned WIDTH = RCA_DEF_WIDTH,
  parameter int unsigned SEG_W = RCA_DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef RCA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned STAGES = rca_stages(WIDTH, SEG_W);

  if (rca_cfg_err(WIDTH, SEG_W) != 0) begin : g_bad_cfg
    $error("pipelined_rca_adder: WIDTH must be a multiple of SEG_W giving 1..16 stages");
  end

  logic w_adv;
  logic w_in_fire;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign w_in_fire = in_valid && w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned DoneW = (k + 1) * SEG_W;

    logic [SEG_W-1:0] w_seg_a;
    logic [SEG_W-1:0] w_seg_b;
    logic [SEG_W-1:0] w_seg_s;
    logic             w_cin;
    logic             w_cout;
    logic             w_valid_d;
    logic [DoneW-1:0] w_sum_d;

    logic             r_valid;
    logic             r_carry;
    logic [DoneW-1:0] r_sum;

    if (k == 0) begin : g_head
      assign w_seg_a   = a[SEG_W-1:0];
      assign w_seg_b   = b[SEG_W-1:0];
      assign w_cin     = carry_in;
      assign w_valid_d = w_in_fire;
      assign w_sum_d   = w_seg_s;
    end else begin : g_body
      assign w_seg_a   = g_stage[k-1].g_fwd.r_a[SEG_W-1:0];
      assign w_seg_b   = g_stage[k-1].g_fwd.r_b[SEG_W-1:0];
      assign w_cin     = g_stage[k-1].r_carry;
      assign w_valid_d = g_stage[k-1].r_valid;
      assign w_sum_d   = {w_seg_s, g_stage[k-1].r_sum};
    end

    rca_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .i_a    (w_seg_a),
      .i_b    (w_seg_b),
      .i_cin  (w_cin),
      .o_s    (w_seg_s),
      .o_cout (w_cout)
    );

    // Bubbles load too, so sum data may change while valid is low.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_adv) begin
        r_valid <= w_valid_d;
        r_carry <= w_cout;
        r_sum   <= w_sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int unsigned UpW = WIDTH - DoneW;

      logic [UpW-1:0] w_a_up;
      logic [UpW-1:0] w_b_up;
      logic [UpW-1:0] r_a;
      logic [UpW-1:0] r_b;

      if (k == 0) begin : g_src_in
        assign w_a_up = a[WIDTH-1:SEG_W];
        assign w_b_up = b[WIDTH-1:SEG_W];
      end else begin : g_src_prev
        assign w_a_up = g_stage[k-1].g_fwd.r_a[WIDTH-k*SEG_W-1:SEG_W];
        assign w_b_up = g_stage[k-1].g_fwd.r_b[WIDTH-k*SEG_W-1:SEG_W];
      end

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a <= w_a_up;
          r_b <= w_b_up;
        end
      end
    end

`ifdef RCA_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_ovf
      logic r_ovf;

      // Operand MSBs arrive here as the top bits of the last forwarded segment.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_seg_a[SEG_W-1] == w_seg_b[SEG_W-1]) &&
                   (w_seg_s[SEG_W-1] != w_seg_a[SEG_W-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign carry_out = g_stage[STAGES-1].r_carry;
`ifdef RCA_OVERFLOW_EN
  assign overflow  = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule
